// File: rtl/sba_pkg.sv
// Shared types and constants for the SBA single-master interconnect.
package sba_pkg;

  localparam int SBA_ADDR_W   = 16;
  localparam int SBA_DATA_W   = 32;
  localparam int SBA_WE_W     = 4;
  localparam int SBA_SLOT_MSB = 15;
  localparam int SBA_SLOT_LSB = 12;
  localparam int SBA_SLOT_W   = SBA_SLOT_MSB - SBA_SLOT_LSB + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } sba_state_e;

  function automatic logic [SBA_SLOT_W-1:0] sba_slot(input logic [SBA_ADDR_W-1:0] addr);
    return addr[SBA_SLOT_MSB:SBA_SLOT_LSB];
  endfunction

endpackage

// File: rtl/sba_ic_wdog.sv
// Wait-cycle watchdog: counts enabled cycles from 0 and flags expiry at TIMEOUT-1.
// Only instantiated when SBA_IC_TIMEOUT_EN is defined.
module sba_ic_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign o_expire = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Next count: saturates at the expiry value so it can never wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && !o_expire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sba_interconnect.sv
// Single-master to NSLV-slave bus interconnect with decode-miss error reporting.
// Optional wait timeout enabled by defining SBA_IC_TIMEOUT_EN.
module sba_interconnect
  import sba_pkg::*;
#(
  parameter int          NSLV     = 4,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [SBA_ADDR_W-1:0]  i_addr,
  input  logic                   i_stb,
  input  logic [SBA_WE_W-1:0]    i_we,
  input  logic [SBA_DATA_W-1:0]  i_dat_w,
  output logic                   o_ack,
  output logic [SBA_DATA_W-1:0]  o_dat_r,
  output logic [SBA_ADDR_W-1:0]  o_s_addr,
  output logic [SBA_WE_W-1:0]    o_s_we,
  output logic [SBA_DATA_W-1:0]  o_s_dat_w,
  output logic [NSLV-1:0]        o_s_stb,
  input  logic [NSLV-1:0]        i_s_ack,
  input  logic [NSLV*32-1:0]     i_s_dat_r,
  output logic                   o_err,
  output logic [SBA_ADDR_W-1:0]  o_err_addr,
  input  logic                   i_err_clr
);

  sba_state_e             state_q, state_d;
  logic [SBA_SLOT_W-1:0]  slot_q, slot_d;
  logic [SBA_ADDR_W-1:0]  s_addr_q, s_addr_d;
  logic [SBA_WE_W-1:0]    s_we_q, s_we_d;
  logic [SBA_DATA_W-1:0]  s_dat_w_q, s_dat_w_d;
  logic [NSLV-1:0]        s_stb_q, s_stb_d;
  logic [SBA_DATA_W-1:0]  resp_q, resp_d;
  logic                   ack_q, ack_d;
  logic [SBA_DATA_W-1:0]  dat_r_q, dat_r_d;
  logic                   err_q, err_d;
  logic [SBA_ADDR_W-1:0]  err_addr_q, err_addr_d;

  logic [SBA_SLOT_W-1:0]  slot_in_s;
  logic                   hit_s;
  logic [NSLV-1:0]        stb_sel_s;
  logic                   sel_ack_s;
  logic [SBA_DATA_W-1:0]  sel_dat_s;
  logic                   expire_s;
  logic                   err_evt_s;
  logic [SBA_ADDR_W-1:0]  err_evt_addr_s;

  assign slot_in_s = sba_slot(i_addr);
  assign hit_s     = (int'(slot_in_s) < NSLV);

`ifdef SBA_IC_TIMEOUT_EN
  sba_ic_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (state_q != WAIT),
    .i_en     (state_q == WAIT),
    .o_expire (expire_s)
  );
`else
  // No watchdog: WAIT is left only on a slave ack (expression is constant false).
  assign expire_s = (TIMEOUT < 0);
`endif

  // Slot decode and selection of the addressed slave's ack/data; other slots are masked out.
  always_comb begin
    stb_sel_s = '0;
    sel_ack_s = 1'b0;
    sel_dat_s = '0;
    for (int k = 0; k < NSLV; k++) begin
      stb_sel_s[k] = (slot_in_s == SBA_SLOT_W'(k));
      sel_ack_s    = sel_ack_s | (i_s_ack[k] & (slot_q == SBA_SLOT_W'(k)));
      sel_dat_s    = sel_dat_s | ({SBA_DATA_W{slot_q == SBA_SLOT_W'(k)}} & i_s_dat_r[k*32 +: 32]);
    end
  end

  // Transaction FSM next-state and request/response register updates.
  always_comb begin
    state_d        = state_q;
    slot_d         = slot_q;
    s_addr_d       = s_addr_q;
    s_we_d         = s_we_q;
    s_dat_w_d      = s_dat_w_q;
    s_stb_d        = s_stb_q;
    resp_d         = resp_q;
    err_evt_s      = 1'b0;
    err_evt_addr_s = '0;
    case (state_q)
      IDLE: begin
        if (i_stb) begin
          slot_d    = slot_in_s;
          s_addr_d  = i_addr;
          s_we_d    = i_we;
          s_dat_w_d = i_dat_w;
          if (hit_s) begin
            s_stb_d = stb_sel_s;
            state_d = WAIT;
          end else begin
            resp_d         = ERR_DATA;
            err_evt_s      = 1'b1;
            err_evt_addr_s = i_addr;
            state_d        = RESP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (sel_ack_s) begin
          resp_d  = sel_dat_s;
          s_stb_d = '0;
          state_d = RESP;
        end else if (expire_s) begin
          resp_d         = ERR_DATA;
          s_stb_d        = '0;
          err_evt_s      = 1'b1;
          err_evt_addr_s = s_addr_q;
          state_d        = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        state_d = GAP;
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        s_stb_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Sticky error capture; a same-cycle error event takes priority over the clear.
  always_comb begin
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (err_evt_s) begin
      if (!err_q) begin
        err_d      = 1'b1;
        err_addr_d = err_evt_addr_s;
      end else begin
        err_d      = 1'b1;
        err_addr_d = err_addr_q;
      end
    end else if (i_err_clr) begin
      err_d      = 1'b0;
      err_addr_d = '0;
    end else begin
      err_d      = err_q;
      err_addr_d = err_addr_q;
    end
  end

  // Master response: a single-cycle pulse registered out of RESP, zero data otherwise.
  always_comb begin
    ack_d   = (state_q == RESP);
    dat_r_d = (state_q == RESP) ? resp_q : '0;
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      s_addr_q   <= '0;
      s_we_q     <= '0;
      s_dat_w_q  <= '0;
      s_stb_q    <= '0;
      resp_q     <= '0;
      ack_q      <= 1'b0;
      dat_r_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      s_addr_q   <= s_addr_d;
      s_we_q     <= s_we_d;
      s_dat_w_q  <= s_dat_w_d;
      s_stb_q    <= s_stb_d;
      resp_q     <= resp_d;
      ack_q      <= ack_d;
      dat_r_q    <= dat_r_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign o_ack      = ack_q;
  assign o_dat_r    = dat_r_q;
  assign o_s_addr   = s_addr_q;
  assign o_s_we     = s_we_q;
  assign o_s_dat_w  = s_dat_w_q;
  assign o_s_stb    = s_stb_q;
  assign o_err      = err_q;
  assign o_err_addr = err_addr_q;

endmodule

// File: doc/sba_interconnect.md
SBA_INTERCONNECT -- requirements
Module: sba_interconnect

Interface
REQ-001 Parameter NSLV, default 4: number of slave channels, 1..16.
REQ-002 Parameter TIMEOUT, default 255: wait-cycle limit before error response, 2..65535.
REQ-003 Parameter ERR_DATA, default 32'hDEAD_BEEF: read data returned on any error response.
REQ-004 Port i_clk  in  1  single clock; all logic on its rising edge.
REQ-005 Port i_rst  in  1  synchronous, active-high reset.
REQ-006 Ports i_addr in 16, i_stb in 1, i_we in 4, i_dat_w in 32: master request; i_addr[15:12] selects the slot.
REQ-007 Ports o_ack out 1, o_dat_r out 32: master response.
REQ-008 Ports o_s_addr out 16, o_s_we out 4, o_s_dat_w out 32: registered request, shared by all slaves.
REQ-009 Ports o_s_stb out NSLV (one-hot strobes), i_s_ack in NSLV, i_s_dat_r in NSLV*32 (slot k at bits [32k+31:32k]).
REQ-010 Ports o_err out 1 (sticky error), o_err_addr out 16 (address of first error), i_err_clr in 1 (clears the error).

Function
REQ-011 FSM states: IDLE, WAIT, RESP, GAP.
REQ-012 IDLE with i_stb=1: latch i_addr, i_we and i_dat_w into o_s_*; slot = i_addr[15:12].
- slot < NSLV: go to WAIT.
- slot >= NSLV: go to RESP with ERR_DATA (decode miss).
REQ-013 WAIT: o_s_stb[slot]=1, all other strobes 0; only i_s_ack[slot] is observed; acks from other slots are ignored.
REQ-014 WAIT with i_s_ack[slot]=1: capture slot read data into a response register, deassert strobe the next cycle, go to RESP; minimum latency i_stb to o_ack is 3 cycles.
REQ-015 RESP: o_ack=1 for exactly one cycle with the response register on o_dat_r; then GAP.
REQ-016 GAP: lasts one cycle and ignores i_stb; the master drops i_stb in the cycle after o_ack; then IDLE.
REQ-017 o_dat_r is 0 in every state except RESP; o_ack is 0 in every state except RESP.
REQ-018 Writes (i_we != 0) follow the same path; the slave's i_s_dat_r is captured but is don't-care to the master.
REQ-019 Error event (decode miss or timeout):
- with o_err=0: set o_err and load o_err_addr;
- with o_err=1: o_err_addr is not overwritten.
REQ-020 i_err_clr=1 clears o_err and o_err_addr to 0 the next cycle. When an error event and i_err_clr occur in the same cycle, the error wins.
REQ-021 i_stb deasserted by the master during WAIT does not abort the transaction; it completes normally.

Reset
REQ-022 i_rst=1 forces, on the next edge: state IDLE; o_ack, o_s_stb, o_err = 0; o_dat_r, o_err_addr, o_s_addr, o_s_we, o_s_dat_w = 0; wait counter = 0.
REQ-023 Reset mid-transaction (WAIT or RESP) abandons it with no o_ack; a late slave ack after reset is ignored.

Configuration
REQ-024 Macro SBA_IC_TIMEOUT_EN defined: WAIT counts cycles from 0. When the count reaches TIMEOUT-1 without ack, the FSM goes to RESP with ERR_DATA and raises the error per REQ-019.
REQ-025 Macro SBA_IC_TIMEOUT_EN undefined: no counter is synthesised; WAIT lasts until the slave acks; errors arise only from decode misses; TIMEOUT is unused.

Structure
REQ-026 Shared package sba_pkg holds: FSM state enum, SBA_ADDR_W=16, SBA_DATA_W=32, SBA_WE_W=4, SBA_SLOT_MSB=15, SBA_SLOT_LSB=12.
REQ-027 One sub-module, sba_ic_wdog: a clear/enable/expire counter of width $clog2(TIMEOUT), instantiated only under SBA_IC_TIMEOUT_EN.

Verification
REQ-028 NSLV=4; read at 16'h2004; slot 2 acks 1 cycle after its strobe with 32'h1234_5678 -> o_s_stb=4'b0100 only; o_ack pulse with o_dat_r=32'h1234_5678; o_err=0.
REQ-029 Write 16'h1000, i_we=4'b0001, i_dat_w=32'h0000_00A5 -> o_s_dat_w=32'h0000_00A5 and o_s_we=4'b0001 while o_s_stb[1]=1; a single o_ack pulse.
REQ-030 NSLV=4; access 16'h7000 -> no slave strobe; o_ack 2 cycles after i_stb with 32'hDEAD_BEEF; o_err=1 and o_err_addr=16'h7000. A second miss at 16'h9000 leaves o_err_addr=16'h7000.
REQ-031 SBA_IC_TIMEOUT_EN defined, TIMEOUT=8; slot 0 never acks -> strobe held for exactly 8 cycles; o_ack with ERR_DATA; o_err=1. Without the macro the strobe stays high, with no ack, for 100+ cycles.
REQ-032 i_rst pulsed during WAIT, then slot 3 acks -> no o_ack and all outputs 0. i_err_clr asserted in the same cycle as a new miss -> o_err remains 1.
